// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
// DMEM_ARB_RR_EN (see dmem_arb_pick) selects round-robin instead of fixed priority.
package dmem_arb_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // 0 = CPU port (m0), 1 = debug/loader port (m1)
    typedef logic req_idx_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the two requesters.
// DMEM_ARB_RR_EN defined: round-robin on contention; undefined: m0 always wins.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
`ifdef DMEM_ARB_RR_EN
    input  req_idx_t last_gnt,
`endif
    output logic     any_req,
    output req_idx_t winner
);

    always_comb begin
        any_req = req0 | req1;
        winner  = 1'b0;
        if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
            // The port that was not granted last takes the slot.
            winner = ~last_gnt;
`else
            winner = 1'b0;
`endif
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 8x16 data memory: IDLE -> ACCESS -> RESP, 3 cycles per
// transaction. Build with DMEM_ARB_RR_EN for round-robin arbitration on contention.
//
// Handshake: a requester holds req with a stable command until its gnt pulses (ACCESS cycle);
// it then drops req or presents a new command. rvalid pulses one cycle after gnt for reads only.
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_wrenable,
    output logic [ADDR_W-1:0] mem_dataadr,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [1:0]        dbg_state
);

    state_t            state_q, state_d;
    req_idx_t          sel_q, sel_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              any_req;
    req_idx_t          winner;

`ifdef DMEM_ARB_RR_EN
    req_idx_t          last_q, last_d;
`endif

    dmem_arb_pick u_pick (
        .req0     (m0_req),
        .req1     (m1_req),
`ifdef DMEM_ARB_RR_EN
        .last_gnt (last_q),
`endif
        .any_req  (any_req),
        .winner   (winner)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        wren_d    = 1'b0;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
`ifdef DMEM_ARB_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    sel_d   = winner;
                    wren_d  = winner ? m1_we    : m0_we;
                    adr_d   = winner ? m1_addr  : m0_addr;
                    wdata_d = winner ? m1_wdata : m0_wdata;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
`ifdef DMEM_ARB_RR_EN
                    last_d  = winner;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
                // wren_q still carries this transaction's we during ACCESS.
                if (!wren_q) begin
                    if (sel_q) begin
                        rdata1_d  = mem_readdata;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = mem_readdata;
                        rvalid0_d = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            wren_q    <= 1'b0;
            adr_q     <= '0;
            wdata_q   <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            wren_q    <= wren_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
`ifdef DMEM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign m0_gnt        = gnt0_q;
    assign m1_gnt        = gnt1_q;
    assign m0_rvalid     = rvalid0_q;
    assign m1_rvalid     = rvalid1_q;
    assign m0_rdata      = rdata0_q;
    assign m1_rdata      = rdata1_q;
    assign mem_wrenable  = wren_q;
    assign mem_dataadr   = adr_q;
    assign mem_writedata = wdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: slot-level model plus literal checks on key results.
// Compile with +define+DMEM_ARB_RR_EN to exercise the round-robin build.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [2:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic        mem_wrenable;
  logic [2:0]  mem_dataadr;
  logic [15:0] mem_writedata, mem_readdata;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;
  logic init_mem = 1'b0;
  int cyc = 0;
  int gnt_port[$];
  int gnt_cyc[$];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wrenable(mem_wrenable), .mem_dataadr(mem_dataadr),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory: writes on the edge, asynchronous read
  logic [15:0] mem [8];
  assign mem_readdata = mem[mem_dataadr];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'(i + 1);
    end else if (mem_wrenable) begin
      mem[mem_dataadr] <= mem_writedata;
    end
  end

  // behavioural model: one 3-cycle slot per accepted request
  logic [15:0] mmem [8];
  int          busy = 0;
  int          t_port = 0;
  logic        t_we = 1'b0;
  logic [2:0]  t_addr = 3'd0;
  logic [15:0] t_wdata = 16'd0;
  logic        last_p = 1'b1;
  logic [1:0]  exp_gnt = 2'b00;
  logic [1:0]  exp_rvalid = 2'b00;
  logic [15:0] exp_rdata0 = 16'd0, exp_rdata1 = 16'd0;
  logic        exp_wren = 1'b0;
  logic [2:0]  exp_adr = 3'd0;
  logic [15:0] exp_wd = 16'd0;

  function automatic int pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
      return (last == 1'b1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    int w;
    if (init_mem) begin
      for (int i = 0; i < 8; i++) mmem[i] = 16'(i + 1);
    end
    if (rst) begin
      if (busy == 1 && t_we) mmem[t_addr] = t_wdata;
      busy = 0; exp_gnt = 2'b00; exp_rvalid = 2'b00; exp_wren = 1'b0;
      exp_rdata0 = 16'd0; exp_rdata1 = 16'd0; exp_adr = 3'd0; exp_wd = 16'd0;
      last_p = 1'b1;
    end else begin
      case (busy)
        0: begin
          exp_gnt = 2'b00; exp_rvalid = 2'b00; exp_wren = 1'b0;
          if (m0_req || m1_req) begin
            w = pick(m0_req, m1_req, last_p);
            t_port = w;
            last_p = (w == 1);
            t_we    = (w == 1) ? m1_we    : m0_we;
            t_addr  = (w == 1) ? m1_addr  : m0_addr;
            t_wdata = (w == 1) ? m1_wdata : m0_wdata;
            exp_gnt[w] = 1'b1;
            exp_wren = t_we; exp_adr = t_addr; exp_wd = t_wdata;
            busy = 1;
          end
        end
        1: begin
          exp_gnt = 2'b00; exp_wren = 1'b0;
          if (t_we) mmem[t_addr] = t_wdata;
          else begin
            if (t_port == 0) exp_rdata0 = mmem[t_addr];
            else exp_rdata1 = mmem[t_addr];
            exp_rvalid[t_port] = 1'b1;
          end
          busy = 2;
        end
        default: begin
          exp_rvalid = 2'b00;
          busy = 0;
        end
      endcase
    end
  end

  // scoreboard helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m0_gnt", 32'(m0_gnt), 32'(exp_gnt[0]));
      chk("m1_gnt", 32'(m1_gnt), 32'(exp_gnt[1]));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rvalid[0]));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rvalid[1]));
      chk("m0_rdata", 32'(m0_rdata), 32'(exp_rdata0));
      chk("m1_rdata", 32'(m1_rdata), 32'(exp_rdata1));
      chk("mem_wrenable", 32'(mem_wrenable), 32'(exp_wren));
      chk("mem_dataadr", 32'(mem_dataadr), 32'(exp_adr));
      chk("mem_writedata", 32'(mem_writedata), 32'(exp_wd));
      chk("one_gnt", 32'(m0_gnt & m1_gnt), 32'd0);
      chk("one_rvalid", 32'(m0_rvalid & m1_rvalid), 32'd0);
      chk("wren_only_access", 32'(mem_wrenable && (dbg_state != 2'(ACCESS))), 32'd0);
    end
    if (m0_gnt) begin gnt_port.push_back(0); gnt_cyc.push_back(cyc); end
    if (m1_gnt) begin gnt_port.push_back(1); gnt_cyc.push_back(cyc); end
  end

  // driver tasks
  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [2:0] a, input logic [15:0] d);
    if (p == 0) begin
      m0_req = v; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = v; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic wait_gnt(input int p);
    int   n;
    logic g;
    n = 0; g = 1'b0;
    while (!g && n < 20) begin
      @(negedge clk);
      g = (p == 1) ? m1_gnt : m0_gnt;
      n++;
    end
    vectors++;
    if (!g) begin
      miscompares++;
      $display("FAIL gnt_timeout port %0d: got no gnt, required gnt within 20 cycles", p);
    end
  endtask

  task automatic txn(input int p, input logic we, input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    set_req(p, 1'b1, we, a, d);
    wait_gnt(p);
    @(posedge clk); #1;
    set_req(p, 1'b0, 1'b0, 3'd0, 16'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    int n;
    int rv_cnt;
    int exp_order [4];
    rst = 1'b1; init_mem = 1'b1;
    set_req(0, 1'b0, 1'b0, 3'd0, 16'd0);
    set_req(1, 1'b0, 1'b0, 3'd0, 16'd0);
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0; init_mem = 1'b0;

    // reset state
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    chk("reset_wren", 32'(mem_wrenable), 32'd0);
    chk("reset_adr", 32'(mem_dataadr), 32'd0);

    // 1: m0 write then read back
    txn(0, 1'b1, 3'd3, 16'h00AA);
    txn(0, 1'b0, 3'd3, 16'h0000);
    chk("t1_m0_rdata", 32'(m0_rdata), 32'h00AA);

    // 2: m1 read of preloaded word
    txn(1, 1'b0, 3'd1, 16'h0000);
    chk("t2_m1_rdata", 32'(m1_rdata), 32'h0002);
    chk("t2_m0_rdata_kept", 32'(m0_rdata), 32'h00AA);

    // 3: both ports requesting continuously for four slots
    pulse_reset();
    gnt_port.delete(); gnt_cyc.delete();
    set_req(0, 1'b1, 1'b0, 3'd2, 16'h0000);
    set_req(1, 1'b1, 1'b0, 3'd4, 16'h0000);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (gnt_port.size() < 4 && n < 40);
    #1;
    set_req(0, 1'b0, 1'b0, 3'd0, 16'd0);
    set_req(1, 1'b0, 1'b0, 3'd0, 16'd0);
    chk("t3_gnt_count", 32'(gnt_port.size()), 32'd4);
`ifdef DMEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    if (gnt_port.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t3_gnt_order_%0d", i), 32'(gnt_port[i]), 32'(exp_order[i]));
      for (int i = 1; i < 4; i++) chk($sformatf("t3_gnt_gap_%0d", i), 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
    end
    repeat (3) @(posedge clk);

    // 4: reset during ACCESS of an m1 read
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 3'd1, 16'h0000);
    wait_gnt(1);
    rst = 1'b1;
    set_req(1, 1'b0, 1'b0, 3'd0, 16'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk("t4_state_idle", 32'(dbg_state), 32'(IDLE));
    chk("t4_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("t4_m1_rdata", 32'(m1_rdata), 32'd0);
    rv_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (m1_rvalid) rv_cnt++;
    end
    chk("t4_no_rvalid", 32'(rv_cnt), 32'd0);
    txn(1, 1'b0, 3'd1, 16'h0000);
    chk("t4_after_m1_rdata", 32'(m1_rdata), 32'h0002);

    // 5: m0 write to 7, m1 reads 7 in the following slot
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 3'd7, 16'hFFFF);
    set_req(1, 1'b1, 1'b0, 3'd7, 16'h0000);
    wait_gnt(0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 3'd0, 16'd0);
    wait_gnt(1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 3'd0, 16'd0);
    repeat (3) @(posedge clk);
    chk("t5_m1_rdata", 32'(m1_rdata), 32'hFFFF);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
